mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum number of cycles a grant is held before forced release (legal range 2..255).
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, fixed to 4 to match the 2-bit select of the downstream 4:1 mux.
REQ-003 SHALL have port clk1, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: request line per mux input (bit0=a, bit1=b, bit2=c, bit3=d).
REQ-006 SHALL have port done, input, 1 bit: consumer indicates the current transfer is complete.
REQ-007 SHALL have port sel, output, 2 bits: registered select driven to the mux sel port.
REQ-008 SHALL have port grant, output, 4 bits: registered one-hot grant, all-zero when idle.
REQ-009 SHALL have port busy, output, 1 bit: high while in GRANT state.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released.

Function
REQ-011 SHALL implement states IDLE and GRANT; all outputs registered.
REQ-012 In IDLE with req != 0: next edge enters GRANT; grant=one-hot of winner; sel=winner index; busy=1; hold counter=0.
REQ-013 Winner SHALL be chosen round-robin: first set req bit searching from (last+1) mod 4 upward with wrap-around; last = index of most recent grant.
REQ-014 In IDLE with req == 0: remain IDLE; grant=0, busy=0; sel holds previous value.
REQ-015 In GRANT, hold counter SHALL increment by 1 per cycle, saturating at MAX_HOLD-1.
REQ-016 GRANT exits to IDLE on the edge where done=1, or req[sel]=0, or counter == MAX_HOLD-1; priority: done, then req drop, then timeout.
REQ-017 On exit: grant=0, busy=0, last=sel; sel holds value; timeout=1 for exactly one cycle only if exit cause was counter expiry with done=0 and req[sel]=1.
REQ-018 At least one IDLE cycle (grant=0) SHALL separate any two grants, including back-to-back grants to the same requester.
REQ-019 Changes to req bits other than req[sel] during GRANT SHALL NOT affect grant or sel.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 grant SHALL never have more than one bit set; sel SHALL equal the index of the set grant bit whenever busy=1.

Reset
REQ-022 While reset=1 (asynchronous, immediate): state=IDLE, sel=2'b00, grant=4'b0000, busy=0, timeout=0, counter=0, last=3 (so requester 0 has first priority).
REQ-023 Reset asserted mid-GRANT SHALL drop grant and busy immediately without a timeout pulse; first arbitration after release follows REQ-022 priority.

Structure
REQ-024 Package mux_sel_pkg SHALL hold the state enum (IDLE, GRANT), NUM_REQ=4, SEL_W=2 and the default MAX_HOLD.
REQ-025 Round-robin winner search SHALL be a combinational sub-module rr_pick (inputs req, last; outputs found, idx).
REQ-026 The top SHALL contain the FSM, hold counter, last pointer and output registers only.

Verification
REQ-027 Reset, then req=4'b0001, done=1 on 3rd GRANT cycle -> grant=0001, sel=00 one edge after req; busy 3 cycles; grant=0000 after done edge; timeout stays 0.
REQ-028 req=4'b1111 held, done pulsed each GRANT cycle -> grant sequence 0001,0010,0100,1000,0001 with one IDLE cycle between each; sel 0,1,2,3,0.
REQ-029 req=4'b0100 held, done=0, MAX_HOLD=8 -> GRANT lasts exactly 8 cycles, timeout=1 for one cycle on exit, then re-grant 0100 after one IDLE cycle.
REQ-030 Grant to requester 1, then drop req[1] while req[3] rises -> exit on the edge req[1] is sampled low, no timeout; next grant 1000, sel=11.
REQ-031 Assert reset for 1 cycle during GRANT to requester 2 -> grant=0000, busy=0, sel=00 immediately; after release with req=4'b0101 -> grant 0001.
REQ-032 Random req/done for 10000 cycles -> grant always one-hot or zero, sel matches grant while busy, no grant exceeds MAX_HOLD cycles.

Source files
------------

// File: rtl/mux_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_pkg
// Purpose  : Shared types and constants for the 4:1 mux select arbiter:
//            FSM state encoding, requester count, select width, default
//            hold limit and a one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

   // Requester count is tied to the 2-bit select of the downstream 4:1 mux
   localparam int NUM_REQ      = 4;
   localparam int SEL_W        = 2;

   // Default number of cycles a grant may be held before forced release
   localparam int MAX_HOLD_DEF = 8;

   // Hold counter width; covers the largest legal MAX_HOLD of 255
   localparam int CNT_W        = 8;

   // Arbiter states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // One-hot decode of a requester index
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage : mux_sel_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin winner search. Looks for the first
//            set request bit starting at (last+1) mod 4 and wrapping around,
//            so the most recently served requester has lowest priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import mux_sel_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   // Candidate index in search order; slot 0 is the highest priority
   logic [SEL_W-1:0]   w_cand [NUM_REQ];
   // Request bit seen at each search slot
   logic [NUM_REQ-1:0] w_hit;

   // Modulo-4 wrap comes for free from the 2-bit addition
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
      assign w_cand[g] = last + SEL_W'(g + 1);
      assign w_hit[g]  = req[w_cand[g]];
   end

   // Lowest-numbered hitting search slot wins
   always_comb begin
      found = |w_hit;
      idx   = '0;
      casez (w_hit)
         4'b???1: idx = w_cand[0];
         4'b??10: idx = w_cand[1];
         4'b?100: idx = w_cand[2];
         4'b1000: idx = w_cand[3];
         default: idx = '0;
      endcase
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Purpose  : Round-robin arbiter driving the select of a 4:1 mux. Grants one
//            requester at a time, holds the grant until the consumer signals
//            done, the request drops, or the hold limit expires (flagged by
//            a one-cycle timeout pulse). Every grant is followed by at least
//            one idle cycle. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
   import mux_sel_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int NUM_REQ  = 4
) (
   input  logic               clk1,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [SEL_W-1:0]   sel,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               timeout
);

   // Counter value at which a held grant is force-released
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_HOLD - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [SEL_W-1:0]   r_last;

   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic               w_req_cur;
   logic               w_cnt_max;
   logic               w_exit;
   logic               w_expire;

   // Next winner relative to the most recently served requester
   rr_pick u_rr_pick (
      .req   (req),
      .last  (r_last),
      .found (w_found),
      .idx   (w_idx)
   );

   // Release conditions while granted; timeout only when expiry is the sole cause
   assign w_req_cur = req[sel];
   assign w_cnt_max = (r_cnt == c_cnt_max);
   assign w_exit    = done | ~w_req_cur | w_cnt_max;
   assign w_expire  = ~done & w_req_cur & w_cnt_max;

   // Arbiter FSM with hold counter, last-served pointer and registered outputs
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 2'd3;
         sel     <= '0;
         grant   <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               // done is ignored here; only requests start a grant
               if (w_found) begin
                  r_state <= GRANT;
                  grant   <= to_onehot(w_idx);
                  sel     <= w_idx;
                  busy    <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  grant   <= '0;
                  busy    <= 1'b0;
               end
            end
            GRANT: begin
               // Other requesters are not looked at until we are back in IDLE
               if (w_exit) begin
                  r_state <= IDLE;
                  grant   <= '0;
                  busy    <= 1'b0;
                  r_last  <= sel;
                  timeout <= w_expire;
               end else if (!w_cnt_max) begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               grant   <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule : mux_sel_arbiter
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Purpose  : Self-checking bench for mux_sel_arbiter: a table of per-cycle
//            vectors with hand-computed outputs, a hand-written asynchronous
//            reset sequence, and a random run checked against invariants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk1;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       tmo;
   } vec_t;

   vec_t vecs[$];

   mux_sel_arbiter #(
      .MAX_HOLD (MAX_HOLD),
      .NUM_REQ  (4)
   ) dut (
      .clk1    (clk1),
      .reset   (reset),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .grant   (grant),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic d,
                      input logic [3:0] g, input logic [1:0] s, input logic b,
                      input logic t);
      vec_t v;
      v.rst = r; v.req = q; v.done = d;
      v.grant = g; v.sel = s; v.busy = b; v.tmo = t;
      vecs.push_back(v);
   endtask

   initial begin
      int run;
      logic [3:0] prev_grant;

      reset = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;

      // ---------------- vector table (rst, req, done | grant, sel, busy, tmo)
      add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);   // reset state
      // single requester, done on third grant cycle
      add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      // all requesting, done each grant cycle: round-robin rotation
      add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0);
      add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
      add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0);
      add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      // requester 1 drops while requester 3 rises
      add(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      add(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      add(0, 4'b1000, 0, 4'b0000, 2'd1, 0, 0);
      add(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
      add(0, 4'b1000, 1, 4'b0000, 2'd3, 0, 0);
      // done in IDLE is ignored
      add(0, 4'b0000, 1, 4'b0000, 2'd3, 0, 0);
      // other request bits changing during a grant have no effect
      add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      // hold limit: 8 busy cycles, timeout pulse, re-grant after one idle
      add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      for (int i = 0; i < 7; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      add(0, 4'b0100, 0, 4'b0000, 2'd2, 0, 1);
      add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      // done coinciding with expiry gives no timeout
      for (int i = 0; i < 7; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      add(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0);
      add(0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

      foreach (vecs[k]) begin
         reset = vecs[k].rst;
         req   = vecs[k].req;
         done  = vecs[k].done;
         @(posedge clk1); #1;
         chk($sformatf("vec%0d.grant", k), 8'(grant), 8'(vecs[k].grant));
         chk($sformatf("vec%0d.sel", k), 8'(sel), 8'(vecs[k].sel));
         chk($sformatf("vec%0d.busy", k), 8'(busy), 8'(vecs[k].busy));
         chk($sformatf("vec%0d.timeout", k), 8'(timeout), 8'(vecs[k].tmo));
      end

      // ---------------- asynchronous reset in the middle of a grant
      reset = 1'b1; req = 4'b0000; done = 1'b0;
      @(posedge clk1); #1;
      reset = 1'b0;
      req   = 4'b0100;
      @(posedge clk1); #1;
      chk("arst.pre_grant", 8'(grant), 8'h04);
      chk("arst.pre_sel", 8'(sel), 8'h02);
      #3;
      reset = 1'b1;
      #1;
      chk("arst.grant", 8'(grant), 8'h00);
      chk("arst.busy", 8'(busy), 8'h00);
      chk("arst.sel", 8'(sel), 8'h00);
      chk("arst.timeout", 8'(timeout), 8'h00);
      @(posedge clk1); #1;
      reset = 1'b0;
      req   = 4'b0101;
      @(posedge clk1); #1;
      chk("arst.post_grant", 8'(grant), 8'h01);
      chk("arst.post_sel", 8'(sel), 8'h00);
      chk("arst.post_timeout", 8'(timeout), 8'h00);

      // ---------------- random traffic checked against invariants
      reset = 1'b1;
      @(posedge clk1); #1;
      reset = 1'b0;
      run = 0;
      prev_grant = 4'b0000;
      for (int n = 0; n < 10000; n++) begin
         req  = 4'($urandom);
         done = ($urandom_range(0, 3) == 0);
         @(posedge clk1); #1;
         chk("rnd.onehot", 8'($countones(grant) <= 1), 8'h01);
         chk("rnd.busy", 8'(busy), 8'(|grant));
         if (busy) begin
            chk("rnd.sel", 8'(grant), 8'(4'b0001 << sel));
            run++;
            chk("rnd.hold", 8'(run <= MAX_HOLD), 8'h01);
         end else begin
            run = 0;
         end
         if (prev_grant != 4'b0000 && grant != 4'b0000)
            chk("rnd.gap", 8'(grant), 8'(prev_grant));
         prev_grant = grant;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mux_sel_arbiter
`default_nettype wire
